// File: rtl/updown_count_pkg.sv
// -----------------------------------------------------------------------------
// updown_count_pkg
// Shared types and constants for the up/down counter sequencer.
//   op_e          : command opcodes carried on cmd_op
//   state_e       : controller FSM states
//   DEFAULT_WIDTH : default counter / command-data width
// -----------------------------------------------------------------------------
package updown_count_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'd0,
      OP_UP     = 2'd1,
      OP_DOWN   = 2'd2,
      OP_BOUNCE = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/updown_count_core.sv
// -----------------------------------------------------------------------------
// updown_core
// Modulo-2^WIDTH up/down counter datapath.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   en         : take one step this cycle
//   load       : load load_val this cycle (wins over en)
//   load_val   : value to load
//   up_down    : step direction, 1 = up
//   count      : current counter value
//   wrap       : high when the step being enabled crosses the modulo boundary
// -----------------------------------------------------------------------------
module updown_core
   import updown_count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         if (up_down) begin
            count <= count + 1'b1;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   // Terminal value in the current direction: the step about to happen wraps.
   assign wrap = en && (up_down ? (count == MAX_VAL) : (count == '0));

endmodule

// File: rtl/updown_count_ctrl.sv
// -----------------------------------------------------------------------------
// updown_count_ctrl
// Command sequencer around updown_core. One command at a time over a
// valid/ready handshake: LOAD, UP n, DOWN n, BOUNCE limit.
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : a command transfers on an edge where both are high;
//                         cmd_ready is high only in IDLE, nothing is queued
//   cmd_op, cmd_data    : opcode and its operand (load value / steps / limit)
//   pause, abort        : honoured in RUN only; abort wins over pause
//   count, dir          : counter value and direction (1 = up)
//   busy                : high in RUN
//   done                : one-cycle pulse on completion or abort
//   wrapped             : sticky, a modulo wrap happened in this/last command
//   state               : FSM state, exposed for observation
// -----------------------------------------------------------------------------
module updown_count_ctrl
   import updown_count_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             wrapped,
   output state_e           state
);

   state_e           state_next;
   op_e              op;
   logic             accept;
   logic             step;
   logic             core_wrap;
   logic             bounce_mode;
   logic [WIDTH-1:0] remaining;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count_inc;

   assign op        = op_e'(cmd_op);
   assign accept    = cmd_valid && (state == ST_IDLE);
   assign step      = (state == ST_RUN) && !abort && !pause;
   assign count_inc = count + 1'b1;

   updown_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .en       (step),
      .load     (accept && (op == OP_LOAD)),
      .load_val (cmd_data),
      .up_down  (dir),
      .count    (count),
      .wrap     (core_wrap)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (op)
                  OP_LOAD:   state_next = ST_DONE;
                  OP_UP,
                  OP_DOWN:   state_next = (cmd_data == '0) ? ST_DONE : ST_RUN;
                  OP_BOUNCE: state_next = ((count == '0) && (cmd_data == '0)) ? ST_DONE : ST_RUN;
                  default:   state_next = ST_DONE;
               endcase
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_next = ST_DONE;
            end else if (!pause) begin
               // Bounce ends on the downward step that lands on zero;
               // counted commands end on their last step.
               if (bounce_mode) begin
                  if (!dir && (count == WIDTH'(1))) state_next = ST_DONE;
               end else if (remaining == WIDTH'(1)) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: cmd_ready = 1'b1;
         ST_RUN:  busy      = 1'b1;
         ST_DONE: done      = 1'b1;
         default: ;
      endcase
   end

   // Command registers: direction, step budget, bounce limit, wrap flag
   always_ff @(posedge clk) begin
      if (reset) begin
         dir         <= 1'b1;
         remaining   <= '0;
         limit       <= '0;
         wrapped     <= 1'b0;
         bounce_mode <= 1'b0;
      end else if (accept) begin
         wrapped <= 1'b0;
         case (op)
            OP_UP: begin
               dir         <= 1'b1;
               remaining   <= cmd_data;
               bounce_mode <= 1'b0;
            end
            OP_DOWN: begin
               dir         <= 1'b0;
               remaining   <= cmd_data;
               bounce_mode <= 1'b0;
            end
            OP_BOUNCE: begin
               limit       <= cmd_data;
               dir         <= (count < cmd_data);
               bounce_mode <= 1'b1;
            end
            default: bounce_mode <= 1'b0;
         endcase
      end else if (step) begin
         if (core_wrap) wrapped <= 1'b1;
         if (bounce_mode) begin
            // Turn around on the edge that reaches the limit; restore the
            // up direction on the edge that reaches zero.
            if (dir && (count_inc == limit)) begin
               dir <= 1'b0;
            end else if (!dir && (count == WIDTH'(1))) begin
               dir <= 1'b1;
            end
         end else begin
            remaining <= remaining - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_updown_count_ctrl.sv
module tb_updown_count_ctrl;
   import updown_count_pkg::*;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic         pause;
   logic         abort;
   logic [W-1:0] count;
   logic         dir;
   logic         busy;
   logic         done;
   logic         wrapped;
   state_e       state;

   always #5 clk = ~clk;

   updown_count_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .pause     (pause),
      .abort     (abort),
      .count     (count),
      .dir       (dir),
      .busy      (busy),
      .done      (done),
      .wrapped   (wrapped),
      .state     (state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command and return just after its accept edge.
   task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data);
      int guard = 0;
      while (!cmd_ready && guard < 20) begin
         tick();
         guard++;
      end
      if (!cmd_ready) check("wait_ready_timeout", 0, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = $urandom_range(0, 255);
   endtask

   // Edges from the accept edge (counted as 1) until done is seen.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 2000) begin
         tick();
         lat++;
      end
      if (!done) check("done_timeout", 0, 1);
   endtask

   // ---------------- behavioural reference model ----------------
   task automatic model_cmd(input int start, input logic start_dir, input int op, input int data,
                            output int fin, output logic wr, output logic fdir, output int steps);
      int s;
      fin = start; wr = 1'b0; fdir = start_dir; steps = 0;
      case (op)
         0: fin = data;
         1: begin
            s = start + data; steps = data; fin = s % 256; wr = (s > 255); fdir = 1'b1;
         end
         2: begin
            s = start - data; steps = data; fin = (s + 256) % 256; wr = (s < 0); fdir = 1'b0;
         end
         default: begin
            // Climb to the limit (if below it), then descend all the way to zero.
            steps = (start < data) ? (data - start) + data : start;
            fin   = 0;
            fdir  = !(start == 0 && data == 0);
         end
      endcase
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] data;
      logic [W-1:0] start;
      logic [W-1:0] exp_count;
      int           exp_lat;
      logic         exp_wrapped;
      logic         exp_dir;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int lat, busy_cycles, done_pulses, left, bad_busy;
      int cur_cnt, e_cnt, e_steps, op_i, data_i;
      logic cur_dir, e_wr, e_dir;
      logic [W-1:0] exp_trace[8];
      logic         exp_dtrace[8];
      logic [3:0]   pause_pat[8];

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
      pause = 1'b0; abort = 1'b0;

      vecs.push_back('{2'd1, 8'h04, 8'hFE, 8'h02, 5,   1'b1, 1'b1});
      vecs.push_back('{2'd2, 8'h05, 8'h10, 8'h0B, 6,   1'b0, 1'b0});
      vecs.push_back('{2'd3, 8'h05, 8'h02, 8'h00, 9,   1'b0, 1'b1});
      vecs.push_back('{2'd1, 8'h00, 8'h33, 8'h33, 1,   1'b0, 1'b1});
      vecs.push_back('{2'd2, 8'h00, 8'h33, 8'h33, 1,   1'b0, 1'b0});
      vecs.push_back('{2'd2, 8'h03, 8'h01, 8'hFE, 4,   1'b1, 1'b0});
      vecs.push_back('{2'd3, 8'h00, 8'h00, 8'h00, 1,   1'b0, 1'b0});
      vecs.push_back('{2'd3, 8'h03, 8'h05, 8'h00, 6,   1'b0, 1'b1});
      vecs.push_back('{2'd3, 8'hFF, 8'hFD, 8'h00, 258, 1'b0, 1'b1});
      vecs.push_back('{2'd1, 8'h01, 8'hFF, 8'h00, 2,   1'b1, 1'b1});
      vecs.push_back('{2'd0, 8'h7E, 8'h00, 8'h7E, 1,   1'b0, 1'b1});
      vecs.push_back('{2'd3, 8'h04, 8'h04, 8'h00, 5,   1'b0, 1'b1});

      tick(); tick();
      reset = 1'b0;

      // ---- reset state ----
      check("rst_count", count, 0);
      check("rst_dir", dir, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wrapped", wrapped, 0);
      check("rst_ready", cmd_ready, 1);

      // ---- LOAD 0xA5: count at accept edge, ready low one cycle ----
      send_cmd(2'd0, 8'hA5);
      check("load_count", count, 8'hA5);
      check("load_done", done, 1);
      check("load_ready_low", cmd_ready, 0);
      tick();
      check("load_ready_back", cmd_ready, 1);
      check("load_done_clr", done, 0);
      check("load_wrapped", wrapped, 0);

      // ---- table-driven vectors ----
      foreach (vecs[i]) begin
         send_cmd(2'd0, vecs[i].start);
         tick();
         send_cmd(vecs[i].op, vecs[i].data);
         wait_done(lat);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
         check($sformatf("vec%0d_wrapped", i), wrapped, vecs[i].exp_wrapped);
         check($sformatf("vec%0d_dir", i), dir, vecs[i].exp_dir);
         check($sformatf("vec%0d_busy", i), busy, 0);
         tick();
         check($sformatf("vec%0d_idle", i), cmd_ready, 1);
      end

      // ---- BOUNCE trace 2 -> 5 -> 0 ----
      exp_trace  = '{8'd3, 8'd4, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      exp_dtrace = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      send_cmd(2'd0, 8'h02);
      tick();
      send_cmd(2'd3, 8'h05);
      check("bnc_start_count", count, 2);
      check("bnc_start_dir", dir, 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("bnc_count%0d", k), count, exp_trace[k]);
         check($sformatf("bnc_dir%0d", k), dir, exp_dtrace[k]);
      end
      check("bnc_done", done, 1);
      check("bnc_wrapped", wrapped, 0);
      tick();

      // ---- DOWN 5 from 0x10 with a 3-cycle pause ----
      pause_pat = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
      send_cmd(2'd0, 8'h10);
      tick();
      send_cmd(2'd2, 8'h05);
      busy_cycles = 0; done_pulses = 0;
      for (int k = 0; k < 8; k++) begin
         if (busy) busy_cycles++;
         pause = pause_pat[k][0];
         tick();
      end
      pause = 1'b0;
      check("pause_count", count, 8'h0B);
      for (int k = 0; k < 4; k++) begin
         if (done) done_pulses++;
         if (busy) busy_cycles++;
         tick();
      end
      check("pause_busy_cycles", busy_cycles, 8);
      check("pause_done_pulses", done_pulses, 1);

      // ---- abort after 10 steps of UP 200, then UP 0 ----
      send_cmd(2'd0, 8'h00);
      tick();
      send_cmd(2'd1, 8'd200);
      for (int k = 0; k < 10; k++) tick();
      check("abort_pre_count", count, 10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_count", count, 10);
      check("abort_done", done, 1);
      tick();
      check("abort_ready", cmd_ready, 1);
      check("abort_hold_count", count, 10);
      send_cmd(2'd1, 8'h00);
      check("up0_done", done, 1);
      check("up0_count", count, 10);
      tick();

      // ---- abort and pause together: abort wins ----
      send_cmd(2'd0, 8'h00);
      tick();
      send_cmd(2'd1, 8'd5);
      tick(); tick();
      abort = 1'b1; pause = 1'b1;
      tick();
      abort = 1'b0; pause = 1'b0;
      check("abort_pause_done", done, 1);
      check("abort_pause_count", count, 2);
      tick();

      // ---- reset in the middle of UP 50 ----
      send_cmd(2'd0, 8'h40);
      tick();
      send_cmd(2'd1, 8'd50);
      for (int k = 0; k < 5; k++) tick();
      reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'd3;
      tick();
      reset = 1'b0; cmd_valid = 1'b0;
      check("midrst_count", count, 0);
      check("midrst_dir", dir, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_ready", cmd_ready, 1);
      tick();
      check("midrst_not_accepted", busy, 0);
      check("midrst_count2", count, 0);

      // ---- randomized commands against the reference model ----
      cur_cnt = 0; cur_dir = 1'b1;
      for (int n = 0; n < 40; n++) begin
         op_i   = $urandom_range(0, 3);
         data_i = (op_i == 1 || op_i == 2) ? $urandom_range(0, 40) : $urandom_range(0, 255);
         model_cmd(cur_cnt, cur_dir, op_i, data_i, e_cnt, e_wr, e_dir, e_steps);
         send_cmd(op_i[1:0], data_i[W-1:0]);
         left = e_steps; bad_busy = 0;
         while (left > 0) begin
            if (!busy || done) bad_busy++;
            pause = ($urandom_range(0, 3) == 0);
            tick();
            if (!pause) left--;
         end
         pause = 1'b0;
         check($sformatf("rnd%0d_busy", n), bad_busy, 0);
         check($sformatf("rnd%0d_done", n), done, 1);
         check($sformatf("rnd%0d_count", n), count, e_cnt);
         check($sformatf("rnd%0d_wrapped", n), wrapped, e_wr);
         check($sformatf("rnd%0d_dir", n), dir, e_dir);
         tick();
         check($sformatf("rnd%0d_idle", n), cmd_ready, 1);
         cur_cnt = e_cnt; cur_dir = e_dir;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_count_ctrl.md
Name: updown_count_ctrl

Overview:
Command-driven sequencer for an 8-bit up/down counter datapath. Accepts one command at a time over a valid/ready interface: load a value, count N steps up, count N steps down, or bounce between the current value, a limit and zero. Handles pause, abort, wrap reporting and completion signalling, so higher-level lab designs never drive enable or direction directly.

Parameters:
WIDTH, 8, counter and command-data width in bits.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command; high only in IDLE.
cmd_op  input  2  0=LOAD, 1=UP, 2=DOWN, 3=BOUNCE.
cmd_data  input  WIDTH  meaning depends on op:
- LOAD: load value.
- UP/DOWN: step count.
- BOUNCE: upper limit.
pause  input  1  freeze counting while high (RUN only).
abort  input  1  terminate current command (RUN only).
count  output  WIDTH  current counter value.
dir  output  1  current direction; 1 = up.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse when a command completes or is aborted.
wrapped  output  1  sticky flag: a modulo wrap occurred during the current/last command.

Behaviour:
- Reset (synchronous, evaluated before everything else):
  - count=0, dir=1, state=IDLE, done=0, busy=0, wrapped=0.
  - Internal step counter and limit cleared.
- States: IDLE, RUN, DONE.
- Handshake: transfer occurs on a clock edge with cmd_valid && cmd_ready. cmd_ready = (state==IDLE). Inputs are ignored otherwise; no queueing.
- On accept:
  - wrapped cleared.
  - LOAD: count<=cmd_data at the accept edge -> DONE.
  - UP/DOWN:
    - dir<=op==UP.
    - remaining<=cmd_data.
    - cmd_data==0 -> DONE (count unchanged); else -> RUN.
  - BOUNCE:
    - limit<=cmd_data.
    - dir<=(count<cmd_data).
    - If count==0 and cmd_data==0 -> DONE; else -> RUN.
- RUN, each cycle, in priority order:
  - abort=1: -> DONE; count frozen at its current value; no step taken this cycle.
  - pause=1: hold count, remaining, dir.
  - Otherwise take one step: count<=count±1 modulo 2^WIDTH.
- Wrap detection: stepping 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down) sets wrapped. It stays set until the next accept or reset.
- UP/DOWN termination:
  - remaining decrements on each step.
  - The step made with remaining==1 -> DONE.
  - N steps without pause take exactly N RUN cycles.
- BOUNCE termination:
  - A step while dir=1 that makes count==limit sets dir<=0 on the same edge.
  - A step while dir=0 that makes count==0 -> DONE; dir restored to 1.
  - BOUNCE never wraps.
- DONE: lasts exactly one cycle with done=1, cmd_ready=0, busy=0; then -> IDLE.
  - Latency from accept to done is 1 cycle for LOAD/zero-length commands, N+1 cycles for N unpaused steps.
- busy is high in RUN only; count is held in IDLE and DONE.
- pause and abort are ignored outside RUN.
- If abort and pause are both high, abort wins.
- reset mid-RUN: the returned state equals the post-reset state; no done pulse.
- All outputs are registered, or decoded from the state register only; there is no combinational path from inputs to outputs.

Decomposition:
- Package updown_count_pkg:
  - op_e enum: LOAD, UP, DOWN, BOUNCE.
  - state_e enum: IDLE, RUN, DONE.
  - Default WIDTH constant.
- Sub-module updown_core:
  - Inputs: clk, reset, en, load, load_val, up_down.
  - Outputs: count, wrap (combinational: en && terminal value in the current direction).
  - Synchronous active-high reset to 0.
  - load has priority over en.
- Controller owns the FSM, remaining, limit, dir and wrapped.

Test Plan:
1. Reset, then LOAD 0xA5 -> count=0xA5 at the accept edge; done one cycle later; cmd_ready low exactly 1 cycle; wrapped=0.
2. LOAD 0xFE, then UP 4 -> count goes FF,00,01,02; busy 4 cycles; done on 5th cycle after accept; wrapped=1.
3. LOAD 0x10, DOWN 5 with pause high for 3 cycles mid-run -> final count 0x0B; busy 8 cycles; done once.
4. LOAD 0x02, BOUNCE 0x05 -> count 3,4,5,4,3,2,1,0; dir falls on the edge reaching 5; done after reaching 0; wrapped=0.
5. UP 200 from 0, abort at RUN cycle 10 -> count=10 frozen; done next cycle; cmd_ready returns; subsequent UP 0 -> immediate done, count 10.
6. Reset asserted during RUN (UP 50) -> next cycle count=0, dir=1, busy=0, done=0, cmd_ready=1; cmd_valid during the reset cycle is not accepted.
